// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the MA load/store path.
// MA has priority over IF, and a starvation counter eventually forces IF through.
// Defining MEM_ARB_TIMEOUT_EN adds a per-transaction watchdog that aborts the access and pulses o_err.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_ready,
  input  logic              i_ma_req,
  input  logic              i_ma_we,
  input  logic [ADDR_W-1:0] i_ma_addr,
  input  logic [DATA_W-1:0] i_ma_wdata,
  output logic [DATA_W-1:0] o_ma_rdata,
  output logic              o_ma_ready,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_stall_if,
  output logic              o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_MA = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_port_arbiter: STARVE_MAX must be 1..15 and TIMEOUT_CYC >= 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_starve_cnt;
  logic [3:0]          w_starve_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_we;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_if_rdata_q;
  logic [DATA_W-1:0]   r_ma_rdata_q;

  logic                w_timeout;
  logic                w_done;
  logic                w_arb;
  logic                w_if_done;
  logic                w_ma_done;
  logic                w_if_cand;
  logic                w_ma_cand;
  logic                w_gnt_if;
  logic                w_gnt_ma;
  logic [DATA_W-1:0]   w_rdata_now;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);

  logic [WD_W-1:0] r_wdog;

  // A real completion in the same cycle as the limit wins over the abort.
  assign w_timeout = (r_state != IDLE) && !i_mem_ready && (r_wdog == WD_LIM);

  always_ff @(posedge i_clk) begin
    if (i_rst || w_arb) begin
      r_wdog <= '0;
    end else if (r_state != IDLE && r_wdog != WD_LIM) begin
      r_wdog <= r_wdog + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done    = (r_state != IDLE) && (i_mem_ready || w_timeout);
  assign w_arb     = (r_state == IDLE) || w_done;
  assign w_if_done = (r_state == GNT_IF) && w_done;
  assign w_ma_done = (r_state == GNT_MA) && w_done;

  // The finishing owner still shows req this cycle; it drops it next cycle.
  assign w_if_cand = i_if_req && !w_if_done;
  assign w_ma_cand = i_ma_req && !w_ma_done;

  assign w_gnt_if = w_arb && w_if_cand && (!w_ma_cand || r_starve_cnt == STARVE_LIM);
  assign w_gnt_ma = w_arb && w_ma_cand && !w_gnt_if;

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    if (w_arb) begin
      if (w_gnt_if) begin
        w_state_nxt  = GNT_IF;
        w_starve_nxt = 4'd0;
      end else if (w_gnt_ma) begin
        w_state_nxt = GNT_MA;
        if (i_if_req && r_starve_cnt != STARVE_LIM) begin
          w_starve_nxt = r_starve_cnt + 4'd1;
        end
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_if_rdata_q <= '0;
      r_ma_rdata_q <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (w_gnt_if) begin
        r_addr <= i_if_addr;
        r_we   <= 1'b0;
      end else if (w_gnt_ma) begin
        r_addr  <= i_ma_addr;
        r_we    <= i_ma_we;
        r_wdata <= i_ma_wdata;
      end
      if (o_if_ready) r_if_rdata_q <= w_rdata_now;
      if (o_ma_ready) r_ma_rdata_q <= w_rdata_now;
    end
  end

  // An aborted access returns zero data.
  assign w_rdata_now = w_timeout ? '0 : i_mem_rdata;

  assign o_if_ready  = w_if_done && !i_rst;
  assign o_ma_ready  = w_ma_done && !i_rst;
  assign o_if_rdata  = o_if_ready ? w_rdata_now : r_if_rdata_q;
  assign o_ma_rdata  = o_ma_ready ? w_rdata_now : r_ma_rdata_q;

  assign o_mem_req   = (r_state != IDLE) && !w_timeout;
  assign o_mem_we    = r_we && (r_state == GNT_MA);
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;

  assign o_stall_if  = i_if_req && !o_if_ready;
  assign o_err       = w_timeout && !i_rst;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between instruction fetch (IF) and the MA-stage load/store path of the 5-stage core.
- Sequences one memory transaction at a time with a req/ready handshake and gives MA priority, since MA holds the older instruction.
- A starvation counter guarantees IF forward progress.
- Emits `stall_if` to the pipeline hazard logic while a fetch is pending.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive MA wins over a waiting IF before IF is forced through (1..15)
- TIMEOUT_CYC, 255, watchdog limit in cycles; used only when MEM_ARB_TIMEOUT_EN is defined

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req  in  1  fetch request; held until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetched word
- if_ready  out  1  one-cycle completion pulse for IF
- ma_req  in  1  MA request; held until ma_ready
- ma_we  in  1  1 = store, 0 = load
- ma_addr  in  ADDR_W  MA address
- ma_wdata  in  DATA_W  store data
- ma_rdata  out  DATA_W  load data
- ma_ready  out  1  one-cycle completion pulse for MA
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion
- stall_if  out  1  = if_req && !if_ready
- err  out  1  one-cycle timeout pulse

Behaviour:
- FSM states: IDLE, GNT_IF, GNT_MA.
  - mem_req = (state != IDLE).
  - mem_addr/mem_we/mem_wdata come from registers latched at grant; mem_we is forced 0 in GNT_IF.
- Arbitration occurs in IDLE, and in any grant state on the cycle mem_ready=1 (back-to-back, no bubble).
  - On a completion cycle, the current owner's req is masked, because the requester drops req the cycle after its ready.
- Priority: ma_req beats if_req, unless starve_cnt == STARVE_MAX; then IF wins.
- Grant actions:
  - Grant to IF: latch if_addr; clear starve_cnt.
  - Grant to MA while if_req is also high: starve_cnt increments, saturating at STARVE_MAX.
  - Grant to MA with if_req low: starve_cnt is unchanged.
- No request at an arbitration point: go to / stay in IDLE, mem_req=0.
- Latency:
  - Request sampled at cycle t in IDLE → mem_req high at t+1.
  - The memory may assert mem_ready in any cycle ≥ t+1 while mem_req is high.
  - Minimum request-to-ready is 1 cycle (ready at t+1).
- Completion (mem_ready && state==GNT_x):
  - x_ready=1 combinationally in that cycle; x_rdata = mem_rdata in that cycle.
  - x_rdata_q captures mem_rdata; outside ready cycles x_rdata holds x_rdata_q.
  - For stores, ma_rdata still updates; its value is don't-care.
- mem_ready while IDLE is ignored: no ready pulse, no state change.
- Latched grant values do not change during a transaction, even if the requester's inputs change illegally.
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ready=0, ma_ready=0, if_rdata=0, ma_rdata=0, err=0, starve_cnt=0.
- Reset mid-transaction: the in-flight access is abandoned; no ready pulse is issued for it; mem_req is low in the cycle after rst.
- stall_if is purely combinational from if_req and if_ready.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+ bit watchdog counts cycles in GNT_IF/GNT_MA without mem_ready and clears on grant.
  - When it reaches TIMEOUT_CYC: abort the transaction, pulse err and the owner's ready for one cycle with rdata=0, drop mem_req, and re-arbitrate that cycle with the owner masked.
- Undefined: no watchdog logic; err is tied to 0; a grant waits on mem_ready indefinitely.

Test Plan:
- rst, then if_req=1 with if_addr=0x100; memory returns 0xDEADBEEF with 1-cycle latency → mem_req at t+1 with mem_addr=0x100, mem_we=0; if_ready pulses at t+1 with if_rdata=0xDEADBEEF; stall_if high at t only.
- if_req and ma_req (store, addr 0x200, data 0x55) raised together → MA granted first with mem_we=1, mem_wdata=0x55; IF granted on MA's mem_ready cycle (no IDLE bubble); IF's ready follows.
- if_req held high while ma_req is re-asserted every completion, STARVE_MAX=4 → 4 MA grants, then an IF grant on the 5th arbitration, then starve_cnt=0 and MA wins again.
- rst asserted for 1 cycle while in GNT_MA with mem_ready low → next cycle state IDLE, mem_req=0, no ma_ready pulse; starve_cnt=0.
- mem_ready=1 while IDLE, no requests → no ready pulses, mem_req stays 0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYC=8: MA load, mem_ready held low → 8 cycles later err=1, ma_ready=1, ma_rdata=0, a pending IF is granted the same cycle; without the macro, mem_req stays high and err stays 0.
